// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared stage indices and default parameters for the pipeline hazard controller.
package riscv_pipe_ctrl_pkg;
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // Forward-select value meaning "use the operand read in ID"
  localparam int FWD_NONE = 0;

  localparam int DEF_STAGES     = 5;
  localparam int DEF_REG_AW     = 5;
  localparam int DEF_LOAD_STAGE = 4;
  localparam int DEF_MEM_STAGE  = 3;
  localparam int DEF_CNT_W      = 32;
endpackage

// File: rtl/riscv_hazard_match.sv
// Youngest-match priority encoder over the shadow destination entries.
// Entry i corresponds to pipeline stage i+STG_EX; lower index is younger.
module riscv_hazard_match
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int NE     = 2,
  parameter int REG_AW = 5,
  parameter int SW     = 3
) (
  input  logic [NE-1:0]             valid,
  input  logic [NE-1:0]             we,
  input  logic [NE-1:0]             ld,
  input  logic [NE-1:0][REG_AW-1:0] rd,
  input  logic [REG_AW-1:0]         rs_idx,
  input  logic                      rs_re,
  output logic                      hit,
  output logic                      is_load,
  output logic [SW-1:0]             stage
);

  // Scan oldest to youngest so the youngest match is the last one written
  always_comb begin
    hit     = 1'b0;
    is_load = 1'b0;
    stage   = '0;
    for (int i = NE-1; i >= 0; i--) begin
      if (valid[i] && we[i] && (rd[i] != '0) && (rd[i] == rs_idx) && rs_re) begin
        hit     = 1'b1;
        is_load = ld[i];
        stage   = SW'(i + STG_EX);
      end
    end
  end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline hazard controller: shadow destination tags, stall/flush vectors,
// registered EX forwarding selects and saturating performance counters.
module riscv_pipe_ctrl
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int STAGES     = DEF_STAGES,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int LOAD_STAGE = DEF_LOAD_STAGE,
  parameter int MEM_STAGE  = DEF_MEM_STAGE,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [REG_AW-1:0]         rs1_idx_i,
  input  logic [REG_AW-1:0]         rs2_idx_i,
  input  logic                      rs1_re_i,
  input  logic                      rs2_re_i,
  input  logic [REG_AW-1:0]         rd_idx_i,
  input  logic                      rd_we_i,
  input  logic                      is_load_i,
  input  logic                      br_taken_i,
  input  logic                      mem_busy_i,
  output logic [STAGES-1:0]         stall_o,
  output logic [STAGES-1:0]         flush_o,
  output logic [$clog2(STAGES)-1:0] fwd_rs1_o,
  output logic [$clog2(STAGES)-1:0] fwd_rs2_o,
  output logic [CNT_W-1:0]          stall_cnt_o,
  output logic [CNT_W-1:0]          flush_cnt_o
);

  localparam int SW = $clog2(STAGES);
  localparam int NE = STAGES - 3;

  // Shadow tags for EX..STAGES-2. The WB entry is never consulted (the
  // register file's write-first read covers it), so the shift stops early.
  logic [STAGES-2:STG_EX]             sh_v, sh_we, sh_ld;
  logic [STAGES-2:STG_EX][REG_AW-1:0] sh_rd;

  // Value each entry takes when it advances: ID inputs for EX, else previous entry
  logic [STAGES-2:STG_EX]             src_v, src_we, src_ld;
  logic [STAGES-2:STG_EX][REG_AW-1:0] src_rd;
  assign src_v  = {sh_v[STAGES-3:STG_EX],  id_valid_i};
  assign src_we = {sh_we[STAGES-3:STG_EX], rd_we_i};
  assign src_ld = {sh_ld[STAGES-3:STG_EX], is_load_i};
  assign src_rd = {sh_rd[STAGES-3:STG_EX], rd_idx_i};

  logic          hit1, hit2, ld1, ld2;
  logic [SW-1:0] stg1, stg2;

  riscv_hazard_match #(.NE(NE), .REG_AW(REG_AW), .SW(SW)) u_match_rs1 (
    .valid(sh_v), .we(sh_we), .ld(sh_ld), .rd(sh_rd),
    .rs_idx(rs1_idx_i), .rs_re(rs1_re_i),
    .hit(hit1), .is_load(ld1), .stage(stg1)
  );

  riscv_hazard_match #(.NE(NE), .REG_AW(REG_AW), .SW(SW)) u_match_rs2 (
    .valid(sh_v), .we(sh_we), .ld(sh_ld), .rd(sh_rd),
    .rs_idx(rs2_idx_i), .rs_re(rs2_re_i),
    .hit(hit2), .is_load(ld2), .stage(stg2)
  );

  // A load too young to forward from when the consumer reaches EX
  logic load_use;
  assign load_use = (hit1 && ld1 && (int'(stg1) <= LOAD_STAGE-2)) ||
                    (hit2 && ld2 && (int'(stg2) <= LOAD_STAGE-2));

  // Select for next cycle: the producer will have moved one stage on
  logic [SW-1:0] fwd1_nx, fwd2_nx;
  assign fwd1_nx = (hit1 && !(ld1 && (int'(stg1) + 1 < LOAD_STAGE))) ? stg1 + SW'(1) : SW'(FWD_NONE);
  assign fwd2_nx = (hit2 && !(ld2 && (int'(stg2) + 1 < LOAD_STAGE))) ? stg2 + SW'(1) : SW'(FWD_NONE);

  // Stall/flush priority: reset, memory wait, taken branch, load-use
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (rst) begin
      stall_o = '0;
    end else if (mem_busy_i) begin
      for (int k = 0; k < STAGES; k++) stall_o[k] = (k <= MEM_STAGE);
      flush_o[MEM_STAGE+1] = 1'b1;
    end else if (br_taken_i) begin
      flush_o[STG_ID] = 1'b1;
      flush_o[STG_EX] = 1'b1;
    end else if (load_use) begin
      stall_o[STG_ID] = 1'b1;
      stall_o[STG_IF] = 1'b1;
      flush_o[STG_EX] = 1'b1;
    end
  end

  // Shadow tags advance unless their stage is held; flush turns an entry into a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_v  <= '0;
      sh_we <= '0;
      sh_ld <= '0;
      sh_rd <= '0;
    end else begin
      for (int k = STG_EX; k <= STAGES-2; k++) begin
        if (!stall_o[k]) begin
          sh_v[k]  <= src_v[k] & ~flush_o[k];
          sh_we[k] <= src_we[k];
          sh_ld[k] <= src_ld[k];
          sh_rd[k] <= src_rd[k];
        end else if (flush_o[k]) begin
          sh_v[k]  <= 1'b0;
        end
      end
    end
  end

  // Forward selects follow the ID instruction into EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_rs1_o <= '0;
      fwd_rs2_o <= '0;
    end else if (stall_o[STG_EX]) begin
      fwd_rs1_o <= fwd_rs1_o;
      fwd_rs2_o <= fwd_rs2_o;
    end else if (flush_o[STG_EX]) begin
      fwd_rs1_o <= '0;
      fwd_rs2_o <= '0;
    end else begin
      fwd_rs1_o <= fwd1_nx;
      fwd_rs2_o <= fwd2_nx;
    end
  end

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if ((|stall_o) && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (br_taken_i && !mem_busy_i && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule
